// File: rtl/occ_hist_monitor.sv
// occ_hist_monitor: per-channel saturating occupancy histogram for FIFO monitoring.
//
// The block samples NUM_CH FIFO occupancies every cycle while in RUN. Each sample is
// binned in stage 1 and counted in stage 2, and the results are read back through a
// registered read port. DRAIN gives the final RUN sample time to commit before done rises.
//
// Optional feature: define OCC_HIST_WATERMARK_EN to add a per-channel peak-occupancy
// register. It is read at rd_bin == NUM_BINS.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start/stop     pulses that begin or resume sampling, and end sampling
//   clear          pulse that zeroes counters, flags and the peak, and returns to IDLE
//   occ            packed occupancies; channel c = occ[c*OCC_WIDTH +: OCC_WIDTH]
//   rd_req/rd_ch/rd_bin   read request; the result appears one edge later
//   rd_data/rd_val        zero-extended read data and a 1-cycle valid pulse
//   running/done          FSM status
//   sample_cnt            number of RUN cycles sampled (saturating)
//   sat                   sticky per-channel flag: a bin reached its maximum count

// One channel: stage-1 bin register, bin counters, sticky sat flag, optional peak.
module occ_hist_chan #(
    parameter int OCC_WIDTH = 16,
    parameter int BIN_RANGE = 8,
    parameter int NUM_BINS  = 16,
    parameter int CNT_WIDTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample_en,   // stage-1 capture this edge
    input  logic                 commit,      // stage-2 increment this edge
    input  logic [OCC_WIDTH-1:0] occ,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CNT_WIDTH-1:0] rd_cnt,
`ifdef OCC_HIST_WATERMARK_EN
    output logic [OCC_WIDTH-1:0] peak,
`endif
    output logic                 sat
);
    localparam int SHIFT = $clog2(BIN_RANGE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_BINS-1:0][CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     bin_q, bin_d;
    logic [OCC_WIDTH-1:0] occ_div;

    // BIN_RANGE is a power of two, so the divide is a shift. The last bin absorbs overflow.
    assign occ_div = occ >> SHIFT;
    assign bin_d   = (occ_div > OCC_WIDTH'(NUM_BINS-1)) ? IDX_W'(NUM_BINS-1)
                                                        : occ_div[IDX_W-1:0];
    assign rd_cnt  = cnt[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            sat   <= 1'b0;
            bin_q <= '0;
        end else if (clear) begin
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            if (sample_en)
                bin_q <= bin_d;
            if (commit) begin
                if (cnt[bin_q] == CNT_MAX)
                    sat <= 1'b1;
                else
                    cnt[bin_q] <= cnt[bin_q] + 1'b1;
            end
        end
    end

`ifdef OCC_HIST_WATERMARK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            peak <= '0;
        else if (clear)
            peak <= '0;
        else if (sample_en && occ > peak)
            peak <= occ;
    end
`endif
endmodule

module occ_hist_monitor #(
    parameter int NUM_CH    = 2,
    parameter int OCC_WIDTH = 16,
    parameter int BIN_RANGE = 8,
    parameter int NUM_BINS  = 16,
    parameter int CNT_WIDTH = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BIN_W    = $clog2(NUM_BINS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        clear,
    input  logic [NUM_CH*OCC_WIDTH-1:0] occ,
    input  logic                        rd_req,
    input  logic [CH_W-1:0]             rd_ch,
    input  logic [BIN_W-1:0]            rd_bin,
    output logic [31:0]                 rd_data,
    output logic                        rd_val,
    output logic                        running,
    output logic                        done,
    output logic [31:0]                 sample_cnt,
    output logic [NUM_CH-1:0]           sat
);
    localparam int IDX_W = BIN_W - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic sample_en;
    logic v1_q;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] ch_cnt;
`ifdef OCC_HIST_WATERMARK_EN
    logic [NUM_CH-1:0][OCC_WIDTH-1:0] ch_peak;
`endif
    logic [31:0] rd_next;

    // Sampling is suppressed on the clear edge, so no stage-1 valid survives a clear.
    assign sample_en = (state_q == RUN) && !clear;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (stop)  state_d = DRAIN;   // stop outranks start
                DRAIN:   state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            v1_q <= sample_en;
            if (clear)
                sample_cnt <= '0;
            else if (sample_en && sample_cnt != 32'hFFFF_FFFF)
                sample_cnt <= sample_cnt + 32'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        occ_hist_chan #(
            .OCC_WIDTH (OCC_WIDTH),
            .BIN_RANGE (BIN_RANGE),
            .NUM_BINS  (NUM_BINS),
            .CNT_WIDTH (CNT_WIDTH),
            .IDX_W     (IDX_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .sample_en (sample_en),
            .commit    (v1_q),
            .occ       (occ[c*OCC_WIDTH +: OCC_WIDTH]),
            .rd_idx    (rd_bin[IDX_W-1:0]),
            .rd_cnt    (ch_cnt[c]),
`ifdef OCC_HIST_WATERMARK_EN
            .peak      (ch_peak[c]),
`endif
            .sat       (sat[c])
        );
    end

    // The read mux samples counters before this edge's increment, so a colliding read
    // returns the pre-increment value.
    always_comb begin
        rd_next = '0;
        if (int'(rd_ch) < NUM_CH) begin
            if (int'(rd_bin) < NUM_BINS)
                rd_next = 32'(ch_cnt[rd_ch]);
`ifdef OCC_HIST_WATERMARK_EN
            else if (int'(rd_bin) == NUM_BINS)
                rd_next = 32'(ch_peak[rd_ch]);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rd_val  <= 1'b0;
        end else begin
            rd_val <= rd_req;
            if (rd_req)
                rd_data <= rd_next;
        end
    end
endmodule

// File: tb/tb_occ_hist_monitor.sv
// Directed bench for occ_hist_monitor. The DUT uses the default parameters except
// CNT_WIDTH=4, so that counter saturation is reachable. Expected values are hand-computed.
module tb_occ_hist_monitor;
`ifdef OCC_HIST_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, rd_req;
    logic [31:0] occ;
    logic [0:0]  rd_ch;
    logic [4:0]  rd_bin;
    logic [31:0] rd_data, sample_cnt;
    logic        rd_val, running, done;
    logic [1:0]  sat;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] s0 [32];
    logic [15:0] s1 [32];

    typedef struct {
        int ch;
        int bin;
        int exp;
    } rd_vec_t;

    occ_hist_monitor #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .occ(occ), .rd_req(rd_req), .rd_ch(rd_ch), .rd_bin(rd_bin),
        .rd_data(rd_data), .rd_val(rd_val), .running(running), .done(done),
        .sample_cnt(sample_cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic rd(input int ch, input int bin, input int exp, input string nm);
        logic [31:0] c, b;
        c = ch;
        b = bin;
        rd_req = 1'b1;
        rd_ch  = c[0:0];
        rd_bin = b[4:0];
        tick();
        rd_req = 1'b0;
        chk({nm, " rd_val"}, {31'd0, rd_val}, 32'd1);
        chk($sformatf("%s ch%0d bin%0d", nm, ch, bin), rd_data, exp);
    endtask

    task automatic run_tbl(input rd_vec_t v[$], input string nm);
        foreach (v[i]) rd(v[i].ch, v[i].bin, v[i].exp, nm);
    endtask

    // start, then n RUN samples taken from s0/s1 with stop on the last, then the DRAIN cycle
    task automatic run(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            occ  = {s1[i], s0[i]};
            stop = (i == n - 1);
            tick();
        end
        stop = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rd_vec_t t2[$], t2b[$], t4[$], t6[$];
        t2  = '{'{0,0,10}, '{0,1,0}, '{0,15,0}, '{1,15,10}, '{1,14,0}, '{1,0,0},
                '{0,17,0}, '{1,31,0}, '{0,16, WM ? 5 : 0}};
        t2b = '{'{0,0,1}, '{0,1,2}, '{0,2,1}, '{0,13,0}, '{0,14,1}, '{0,15,3},
                '{1,8,8}, '{1,7,0}, '{1,9,0}};
        t4  = '{'{0,0,0}, '{1,0,0}, '{0,0,0}, '{1,15,0}};
        t6  = '{'{0,16, WM ? 40 : 0}, '{1,16, WM ? 9 : 0}, '{0,0,2}, '{0,5,1}};

        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        rd_req = 1'b0; rd_ch = '0; rd_bin = '0; occ = '0;
        tick(); tick();
        chk("reset running", {31'd0, running}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset sample_cnt", sample_cnt, 0);
        chk("reset sat", {30'd0, sat}, 0);
        chk("reset rd_val", {31'd0, rd_val}, 0);
        chk("reset rd_data", rd_data, 0);
        reset = 1'b1;
        tick();

        // T1: reset asserted in the middle of RUN while a read is being requested
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("T1 running", {31'd0, running}, 1);
        chk("T1 sample_cnt pre", sample_cnt, 2);
        rd_req = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("T1 async running", {31'd0, running}, 0);
        chk("T1 async sample_cnt", sample_cnt, 0);
        tick();
        chk("T1 held rd_val", {31'd0, rd_val}, 0);
        chk("T1 held done", {31'd0, done}, 0);
        rd_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("T1 idle after reset", {31'd0, running}, 0);
        rd(0, 0, 0, "T1");

        // T2: basic binning with clamping into the last bin
        for (int i = 0; i < 10; i++) begin s0[i] = 16'd5; s1[i] = 16'd200; end
        run(10);
        chk("T2 done", {31'd0, done}, 1);
        chk("T2 running", {31'd0, running}, 0);
        chk("T2 sample_cnt", sample_cnt, 10);
        run_tbl(t2, "T2");

        // T2b: bin edges; 65535 clamps into bin 15
        do_clear();
        chk("T2b clear done", {31'd0, done}, 0);
        chk("T2b clear sample_cnt", sample_cnt, 0);
        s0[0] = 7;   s0[1] = 8;   s0[2] = 8;   s0[3] = 16;
        s0[4] = 119; s0[5] = 120; s0[6] = 127; s0[7] = 16'hFFFF;
        for (int i = 0; i < 8; i++) s1[i] = 16'd64;
        run(8);
        chk("T2b sample_cnt", sample_cnt, 8);
        run_tbl(t2b, "T2b");

        // T3: saturation; ch1 reaches exactly 15 without an attempted overflow
        do_clear();
        for (int i = 0; i < 20; i++) begin
            s0[i] = 16'd0;
            s1[i] = (i < 15) ? 16'd0 : 16'd200;
        end
        run(20);
        chk("T3 sat", {30'd0, sat}, 32'b01);
        chk("T3 sample_cnt", sample_cnt, 20);
        rd(0, 0, 15, "T3");
        rd(1, 0, 15, "T3");
        rd(1, 15, 5, "T3");

        // T4: DONE->RUN keeps counts, then a clear mid-RUN wipes everything
        occ = '0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        chk("T4 sample_cnt before clear", sample_cnt, 26);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("T4 running", {31'd0, running}, 0);
        chk("T4 done", {31'd0, done}, 0);
        chk("T4 sample_cnt", sample_cnt, 0);
        chk("T4 sat", {30'd0, sat}, 0);
        run_tbl(t4, "T4");
        for (int i = 0; i < 3; i++) begin s0[i] = 0; s1[i] = 0; end
        run(3);
        chk("T4 sample_cnt after", sample_cnt, 3);
        rd(0, 0, 3, "T4");
        rd(1, 0, 3, "T4");

        // T5: a read colliding with an increment, and start+stop together in RUN
        do_clear();
        occ = '0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        rd_req = 1'b1; rd_ch = 1'b0; rd_bin = 5'd0;
        tick();
        chk("T5 collide rd_val", {31'd0, rd_val}, 1);
        chk("T5 collide rd_data", rd_data, 4);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; rd_req = 1'b0;
        chk("T5 next rd_data", rd_data, 5);
        chk("T5 drain running", {31'd0, running}, 0);
        chk("T5 drain done", {31'd0, done}, 0);
        tick();
        chk("T5 done", {31'd0, done}, 1);
        chk("T5 rd_val pulse", {31'd0, rd_val}, 0);
        chk("T5 sample_cnt", sample_cnt, 7);
        rd(0, 0, 7, "T5");

        // T6: watermark slot
        do_clear();
        s0[0] = 3; s0[1] = 40; s0[2] = 7;
        for (int i = 0; i < 3; i++) s1[i] = 16'd9;
        run(3);
        run_tbl(t6, "T6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
